// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants, state encoding and decode helper for the
// ALU issue/writeback sequencer.
package alu_issue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // ALU function code is {bit30 qualifier, funct3}
  localparam logic [3:0] ALU_ADD  = {1'b0, F3_ADD_SUB};
  localparam logic [3:0] ALU_SUB  = {1'b1, F3_ADD_SUB};
  localparam logic [3:0] ALU_SLL  = {1'b0, F3_SLL};
  localparam logic [3:0] ALU_SLT  = {1'b0, F3_SLT};
  localparam logic [3:0] ALU_SLTU = {1'b0, F3_SLTU};
  localparam logic [3:0] ALU_XOR  = {1'b0, F3_XOR};
  localparam logic [3:0] ALU_SRL  = {1'b0, F3_SRL_SRA};
  localparam logic [3:0] ALU_SRA  = {1'b1, F3_SRL_SRA};
  localparam logic [3:0] ALU_OR   = {1'b0, F3_OR};
  localparam logic [3:0] ALU_AND  = {1'b0, F3_AND};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       use_imm;
    logic [3:0] func;
  } dec_t;

  // Classify an instruction word; OP-IMM only honours bit30 for SRLI/SRAI
  function automatic dec_t decode_instr(input logic [31:0] instr);
    dec_t       d;
    logic [2:0] f3;
    f3 = instr[14:12];
    d  = '0;
    case (instr[6:0])
      OPC_OP: begin
        d.legal = 1'b1;
        d.func  = {instr[30], f3};
      end
      OPC_OP_IMM: begin
        d.legal   = 1'b1;
        d.use_imm = 1'b1;
        d.func    = {(f3 == F3_SRL_SRA) && instr[30], f3};
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// alu_issue_rf: 2^RF_AW x XLEN register file, two read ports plus a debug
// read port, one write port; x0 reads as zero and ignores writes.
module alu_issue_rf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RF_AW-1:0] i_ra1,
  input  logic [RF_AW-1:0] i_ra2,
  input  logic [RF_AW-1:0] i_dbg_ra,
  input  logic             i_we,
  input  logic [RF_AW-1:0] i_wa,
  input  logic [XLEN-1:0]  i_wd,
  output logic [XLEN-1:0]  o_rd1,
  output logic [XLEN-1:0]  o_rd2,
  output logic [XLEN-1:0]  o_dbg_rd
);

  localparam int unsigned DEPTH = 2 ** RF_AW;

  logic [XLEN-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, x0 never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1    = (i_ra1 == '0)    ? '0 : r_mem[i_ra1];
  assign o_rd2    = (i_ra2 == '0)    ? '0 : r_mem[i_ra2];
  assign o_dbg_rd = (i_dbg_ra == '0) ? '0 : r_mem[i_dbg_ra];

endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue/writeback sequencer for the 32-bit ALU.
// IDLE -> LOAD -> EXEC, one RV32I OP/OP-IMM instruction per 3 cycles.
// Optional: define ALU_ISSUE_SEQ_RETIRE_CNT_EN to add the retire_cnt output.
module alu_issue_seq
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [XLEN-1:0]  alu_in_a,
  output logic [XLEN-1:0]  alu_in_b,
  output logic             alu_wren_a,
  output logic             alu_wren_b,
  output logic [3:0]       alu_func,
  input  logic [XLEN-1:0]  alu_result,
  output logic             done,
  output logic             err,
  output logic [XLEN-1:0]  wb_data,
  input  logic [RF_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]  dbg_data
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0]      retire_cnt
`endif
);

  state_t           r_state;
  logic             r_ready;
  logic             r_legal;
  logic [RF_AW-1:0] r_rd;
  logic [XLEN-1:0]  r_in_a;
  logic [XLEN-1:0]  r_in_b;
  logic             r_wren;
  logic [3:0]       r_func;
  logic             r_done;
  logic             r_err;
  logic [XLEN-1:0]  r_wb;

  dec_t             w_dec;
  logic [XLEN-1:0]  w_rs1_data;
  logic [XLEN-1:0]  w_rs2_data;
  logic [XLEN-1:0]  w_imm;
  logic             w_we;

  assign w_dec = decode_instr(instr);
  assign w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_we  = (r_state == S_EXEC) && r_legal;

  // Operands are read while the word is presented so they are already on
  // the ALU ports throughout LOAD; the only write lands at the EXEC edge.
  alu_issue_rf #(
    .XLEN  (XLEN),
    .RF_AW (RF_AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .i_ra1    (RF_AW'(instr[19:15])),
    .i_ra2    (RF_AW'(instr[24:20])),
    .i_dbg_ra (dbg_addr),
    .i_we     (w_we),
    .i_wa     (r_rd),
    .i_wd     (alu_result),
    .o_rd1    (w_rs1_data),
    .o_rd2    (w_rs2_data),
    .o_dbg_rd (dbg_data)
  );

  // Sequencer FSM with registered, state-decoded outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_legal <= 1'b0;
      r_rd    <= '0;
      r_in_a  <= '0;
      r_in_b  <= '0;
      r_wren  <= 1'b0;
      r_func  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wb    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_state <= S_LOAD;
            r_ready <= 1'b0;
            r_legal <= w_dec.legal;
            r_rd    <= RF_AW'(instr[11:7]);
            r_in_a  <= w_rs1_data;
            r_in_b  <= w_dec.use_imm ? w_imm : w_rs2_data;
            r_func  <= w_dec.func;
            r_wren  <= w_dec.legal;
          end
        end
        S_LOAD: begin
          r_state <= S_EXEC;
          r_wren  <= 1'b0;
          r_done  <= 1'b1;
          r_err   <= !r_legal;
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          if (r_legal) r_wb <= alu_result;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_wren  <= 1'b0;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign alu_in_a    = r_in_a;
  assign alu_in_b    = r_in_b;
  assign alu_wren_a  = r_wren;
  assign alu_wren_b  = r_wren;
  assign alu_func    = r_func;
  assign done        = r_done;
  assign err         = r_err;
  assign wb_data     = r_wb;

`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  // Count legal retirements only; wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_retire_cnt <= '0;
    else if (w_we) r_retire_cnt <= r_retire_cnt + 32'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: directed bench for alu_issue_seq with an architectural
// model (register array + per-instruction phase) and a reference ALU.
`timescale 1ns/1ps
module tb_alu_issue_seq;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = 32'h0;
  logic [31:0] alu_in_a, alu_in_b;
  logic        alu_wren_a, alu_wren_b;
  logic [3:0]  alu_func;
  logic [31:0] alu_result;
  logic        done, err;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  alu_issue_seq #(.XLEN(32), .RF_AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_wren_a  (alu_wren_a),
    .alu_wren_b  (alu_wren_b),
    .alu_func    (alu_func),
    .alu_result  (alu_result),
    .done        (done),
    .err         (err),
    .wb_data     (wb_data),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour
  function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'h0;
    endcase
  endfunction

  // Environment ALU: operand registers loaded by the DUT, combinational result
  logic [31:0] alu_a_q = 32'h0;
  logic [31:0] alu_b_q = 32'h0;
  always @(posedge clk) begin
    if (alu_wren_a) alu_a_q <= alu_in_a;
    if (alu_wren_b) alu_b_q <= alu_in_b;
  end
  assign alu_result = alu_ref(alu_func, alu_a_q, alu_b_q);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural model: phase 0 idle, 1 operands on bus, 2 retiring
  int          m_phase = 0;
  logic        m_legal = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_a = 32'h0, m_b = 32'h0, m_res = 32'h0, m_wb = 32'h0, m_cnt = 32'h0;
  logic [3:0]  m_func = 4'h0;
  logic [31:0] m_rf [32];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = 0;
      m_legal = 1'b0;
      m_wb    = 32'h0;
      m_cnt   = 32'h0;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    end else begin
      case (m_phase)
        0: if (instr_valid) begin
          m_rd  = instr[11:7];
          m_a   = m_rf[instr[19:15]];
          if (instr[6:0] == OPC_OP) begin
            m_legal = 1'b1;
            m_b     = m_rf[instr[24:20]];
            m_func  = {instr[30], instr[14:12]};
          end else if (instr[6:0] == OPC_OP_IMM) begin
            m_legal = 1'b1;
            m_b     = {{20{instr[31]}}, instr[31:20]};
            m_func  = {(instr[14:12] == F3_SRL_SRA) ? instr[30] : 1'b0, instr[14:12]};
          end else begin
            m_legal = 1'b0;
          end
          m_res   = alu_ref(m_func, m_a, m_b);
          m_phase = 1;
        end
        1: m_phase = 2;
        default: begin
          if (m_legal) begin
            if (m_rd != 5'd0) m_rf[m_rd] = m_res;
            m_wb  = m_res;
            m_cnt = m_cnt + 32'd1;
          end
          m_phase = 0;
        end
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("instr_ready", 32'(instr_ready), 32'(m_phase == 0));
      check("alu_wren_a", 32'(alu_wren_a), 32'(m_phase == 1 && m_legal));
      check("alu_wren_b", 32'(alu_wren_b), 32'(m_phase == 1 && m_legal));
      check("done", 32'(done), 32'(m_phase == 2));
      check("err", 32'(err), 32'(m_phase == 2 && !m_legal));
      check("wb_data", wb_data, m_wb);
      check("dbg_data", dbg_data, m_rf[dbg_addr]);
      if (!rst) begin
        check("rst_alu_in_a", alu_in_a, 32'h0);
        check("rst_alu_in_b", alu_in_b, 32'h0);
        check("rst_alu_func", 32'(alu_func), 32'h0);
      end else if (m_phase == 1 && m_legal) begin
        check("alu_in_a", alu_in_a, m_a);
        check("alu_in_b", alu_in_b, m_b);
        check("alu_func", 32'(alu_func), 32'(m_func));
      end else if (m_phase == 2 && m_legal) begin
        check("alu_func_exec", 32'(alu_func), 32'(m_func));
      end
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
      check("retire_cnt", retire_cnt, m_cnt);
`endif
    end
  end

  logic [31:0] cap_a, cap_b;
  logic [3:0]  cap_func;
  logic        cap_wren, cap_err;
  int          cap_lat;

  // Present one word from IDLE, capture LOAD/EXEC outputs, return in IDLE
  task automatic issue(input logic [31:0] w);
    int k;
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    cap_a    = alu_in_a;
    cap_b    = alu_in_b;
    cap_func = alu_func;
    cap_wren = alu_wren_a;
    k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 32'h1);
    cap_lat = k;
    cap_err = err;
    @(negedge clk);
  endtask

  logic [31:0] cnt_before;
  int          acc [3];
  logic [31:0] vals [3];
  int          na;

  initial begin
    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(instr_ready), 32'h1);
    check("reset_wb", wb_data, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);

    // ADDI x1,x0,5
    dbg_addr = 5'd1;
    issue(32'h00500093);
    check("addi_lat", 32'(cap_lat), 32'd1);
    check("addi_a", cap_a, 32'h0);
    check("addi_b", cap_b, 32'h5);
    check("addi_func", 32'(cap_func), 32'h0);
    check("addi_x1", dbg_data, 32'h5);

    // ADDI x2,x0,7 ; SUB x3,x1,x2
    issue(32'h00700113);
    dbg_addr = 5'd3;
    issue(32'h402081B3);
    check("sub_func", 32'(cap_func), 32'h8);
    check("sub_x3", dbg_data, 32'hFFFFFFFE);
    check("sub_wb", wb_data, 32'hFFFFFFFE);

    // x1 = 0x80000000 via ADDI/SLLI, then SRAI x4,x1,4
    dbg_addr = 5'd1;
    issue(32'h00100093);
    issue(32'h01F09093);
    check("slli_x1", dbg_data, 32'h80000000);
    dbg_addr = 5'd4;
    issue(32'h4040D213);
    check("srai_func", 32'(cap_func), 32'hD);
    check("srai_x4", dbg_data, 32'hF8000000);

    // ADDI x5,x0,-1: bit30 set in immediate must not reach func
    dbg_addr = 5'd5;
    issue(32'hFFF00293);
    check("addim1_func", 32'(cap_func), 32'h0);
    check("addim1_x5", dbg_data, 32'hFFFFFFFF);

    // ADDI x0,x0,9 then an illegal load word
    dbg_addr = 5'd0;
    issue(32'h00900013);
    check("x0w_err", 32'(cap_err), 32'h0);
    check("x0w_dbg", dbg_data, 32'h0);
    check("x0w_wb", wb_data, 32'h9);
    dbg_addr = 5'd1;
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
    cnt_before = retire_cnt;
`endif
    issue(32'h00002083);
    check("ill_err", 32'(cap_err), 32'h1);
    check("ill_wren", 32'(cap_wren), 32'h0);
    check("ill_x1", dbg_data, 32'h80000000);
    check("ill_wb", wb_data, 32'h9);
`ifdef ALU_ISSUE_SEQ_RETIRE_CNT_EN
    check("ill_cnt", retire_cnt, cnt_before);
    check("cnt_value", retire_cnt, 32'd8);
`endif

    // Back-to-back ADD x1,x1,x1 with instr_valid held high
    issue(32'h00100093);
    instr       = 32'h001080B3;
    instr_valid = 1'b1;
    na = 0;
    for (int c = 0; c < 9; c++) begin
      if (na == 3) instr_valid = 1'b0;
      else if (instr_ready) begin
        acc[na]  = c;
        vals[na] = dbg_data;
        na++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    check("b2b_accepts", 32'(na), 32'd3);
    check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    check("b2b_v1", vals[1], 32'h2);
    check("b2b_v2", vals[2], 32'h4);
    check("b2b_x1", dbg_data, 32'h8);

    // Reset during LOAD of ADDI x6,x0,3
    dbg_addr    = 5'd6;
    instr       = 32'h00300313;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_x6", dbg_data, 32'h0);
    check("mid_rst_ready", 32'(instr_ready), 32'h1);
    check("mid_rst_done", 32'(done), 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    issue(32'h00300313);
    check("post_rst_x6", dbg_data, 32'h3);
    check("post_rst_wb", wb_data, 32'h3);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
